// File: rtl/eth_pkg.sv
// rtl/eth_pkg.sv - shared types, constants and helpers for the Ethernet FCS path
package eth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        PAD  = 2'd2,
        FCS  = 2'd3
    } fcs_state_e;

    localparam int unsigned ETH_MIN_FRAME = 60;
    localparam int unsigned ETH_FCS_LEN   = 4;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC32_POLY    = 32'h04C1_1DB7;

    function automatic logic [7:0] bitrev8(input logic [7:0] x);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = x[7-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/eth_fcs_append_if.sv
// rtl/eth_fcs_append_if.sv - byte stream in/out bundle for the FCS appender
interface eth_fcs_append_if;
    logic       s_valid;
    logic [7:0] s_data;
    logic       s_last;
    logic       s_ready;
    logic       m_valid;
    logic [7:0] m_data;
    logic       m_last;
    logic       m_ready;
    logic       fcs_done;
    logic       busy;

    modport master (
        output s_valid, s_data, s_last, m_ready,
        input  s_ready, m_valid, m_data, m_last, fcs_done, busy
    );

    modport slave (
        input  s_valid, s_data, s_last, m_ready,
        output s_ready, m_valid, m_data, m_last, fcs_done, busy
    );
endinterface

// File: rtl/crc32_d8.sv
// rtl/crc32_d8.sv - byte-wide CRC-32 engine, MSB-first register fed LSB-first per byte
module crc32_d8
    import eth_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  data,
    input  logic        crc_en,
    input  logic        crc_clr,
    output logic [31:0] crc_data
);

    logic [31:0] crc_q;
    logic [31:0] crc_d;

    // Wire bit 0 goes first, so data[0] is shifted in first.
    function automatic logic [31:0] crc_step8(input logic [31:0] c_in, input logic [7:0] d);
        logic [31:0] c;
        logic        fb;
        c = c_in;
        for (int i = 0; i < 8; i++) begin
            fb = c[31] ^ d[i];
            c  = {c[30:0], 1'b0} ^ (fb ? CRC32_POLY : 32'h0);
        end
        return c;
    endfunction

    always_comb begin
        crc_d = crc_q;
        if (crc_clr) begin
            crc_d = CRC32_INIT;
        end else if (crc_en) begin
            crc_d = crc_step8(crc_q, data);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_q <= CRC32_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_data = crc_q;

endmodule

// File: rtl/eth_fcs_append.sv
// rtl/eth_fcs_append.sv - Ethernet TX sequencer: pass-through, zero pad, append FCS
module eth_fcs_append
    import eth_pkg::*;
#(
    parameter bit          PAD_EN  = 1'b1,
    parameter int unsigned MIN_LEN = ETH_MIN_FRAME
) (
    input  logic            clk,
    input  logic            rst,
    eth_fcs_append_if.slave bus
);

    localparam logic [16:0] MIN_LEN_W = 17'(MIN_LEN);

    fcs_state_e  state_q, state_d;
    logic [15:0] byte_cnt_q, byte_cnt_d;
    logic [1:0]  fcs_idx_q, fcs_idx_d;
    logic        fcs_done_q, fcs_done_d;

    logic        crc_en;
    logic        crc_clr;
    logic [7:0]  crc_in;
    logic [31:0] crc_data;
    logic [7:0]  fcs_raw;
    logic [16:0] cnt_inc;
    logic [15:0] cnt_sat;

    logic        s_ready;
    logic        m_valid;
    logic [7:0]  m_data;
    logic        m_last;

    assign crc_in  = (state_q == PAD) ? 8'h00 : bus.s_data;
    // Wide increment so the comparison against MIN_LEN never wraps.
    assign cnt_inc = {1'b0, byte_cnt_q} + 17'd1;
    assign cnt_sat = (byte_cnt_q == 16'hFFFF) ? byte_cnt_q : byte_cnt_q + 16'd1;

    always_comb begin
        case (fcs_idx_q)
            2'd0:    fcs_raw = crc_data[31:24];
            2'd1:    fcs_raw = crc_data[23:16];
            2'd2:    fcs_raw = crc_data[15:8];
            default: fcs_raw = crc_data[7:0];
        endcase
    end

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        fcs_idx_d  = fcs_idx_q;
        fcs_done_d = 1'b0;
        crc_en     = 1'b0;
        crc_clr    = 1'b0;
        s_ready    = 1'b0;
        m_valid    = 1'b0;
        m_data     = 8'h00;
        m_last     = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.s_valid) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                m_valid = bus.s_valid;
                m_data  = bus.s_data;
                s_ready = bus.m_ready;
                if (bus.s_valid && bus.m_ready) begin
                    crc_en     = 1'b1;
                    byte_cnt_d = cnt_sat;
                    if (bus.s_last) begin
                        state_d = (PAD_EN && (cnt_inc < MIN_LEN_W)) ? PAD : FCS;
                    end
                end
            end
            PAD: begin
                m_valid = 1'b1;
                if (bus.m_ready) begin
                    crc_en     = 1'b1;
                    byte_cnt_d = cnt_sat;
                    if (cnt_inc >= MIN_LEN_W) begin
                        state_d = FCS;
                    end
                end
            end
            FCS: begin
                m_valid = 1'b1;
                m_data  = ~bitrev8(fcs_raw);
                m_last  = (fcs_idx_q == 2'd3);
                if (bus.m_ready) begin
                    if (fcs_idx_q == 2'd3) begin
                        state_d    = IDLE;
                        crc_clr    = 1'b1;
                        byte_cnt_d = 16'd0;
                        fcs_idx_d  = 2'd0;
                        fcs_done_d = 1'b1;
                    end else begin
                        fcs_idx_d = fcs_idx_q + 2'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            byte_cnt_q <= 16'd0;
            fcs_idx_q  <= 2'd0;
            fcs_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            fcs_idx_q  <= fcs_idx_d;
            fcs_done_q <= fcs_done_d;
        end
    end

    crc32_d8 u_crc (
        .clk      (clk),
        .rst_n    (~rst),
        .data     (crc_in),
        .crc_en   (crc_en),
        .crc_clr  (crc_clr),
        .crc_data (crc_data)
    );

    assign bus.s_ready  = s_ready;
    assign bus.m_valid  = m_valid;
    assign bus.m_data   = m_data;
    assign bus.m_last   = m_last;
    assign bus.fcs_done = fcs_done_q;
    assign bus.busy     = (state_q != IDLE);

endmodule
